// File: rtl/pri_arbiter8_pkg.sv
// Shared constants and FSM state type for the eight-requester arbiter.
package pri_arbiter8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/pri_arbiter8_pick.sv
// Combinational 8-to-3 priority pick: the highest set bit wins.
module prio_pick8
    import pri_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        // Ascending scan so the last (highest) set bit overrides lower ones.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_arbiter8.sv
// Eight-requester arbiter: fixed or round-robin priority, grant hold with
// release handshake and a HOLD_MAX timeout. All outputs are registered.
module pri_arbiter8
    import pri_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_en,
    // `release` is a reserved word in SystemVerilog, hence the suffix.
    input  logic             release_i,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_hold;

    logic [IDX_W-1:0]   w_rot_amt;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic               w_early_exit;
    logic               w_hold_done;

    // Rotating right by last makes index last-1 land on bit 7, so a single
    // highest-bit pick yields the descending round-robin order.
    assign w_rot_amt = rr_en ? r_last : '0;

    always_comb begin
        w_rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[IDX_W'(i) + w_rot_amt];
        end
    end

    prio_pick8 u_pick (
        .i_vec (w_rot),
        .o_idx (w_pick_idx),
        .o_any (w_any)
    );

    assign w_win        = w_pick_idx + w_rot_amt;
    assign w_early_exit = release_i || !req[grant_idx];
    assign w_hold_done  = (r_hold == CNT_W'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= '0;
            r_hold      <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (w_any) begin
                        r_state     <= ST_GRANT;
                        r_last      <= w_win;
                        r_hold      <= '0;
                        grant       <= N_REQ'(1) << w_win;
                        grant_idx   <= w_win;
                        grant_valid <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_early_exit || w_hold_done) begin
                        r_state     <= ST_IDLE;
                        r_hold      <= '0;
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        // Release or request drop suppresses the timeout pulse.
                        timeout     <= !w_early_exit;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pri_arbiter8.sv
// Directed self-checking bench for pri_arbiter8 (HOLD_MAX = 4).
module tb_pri_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rr_en;
    logic       release_i;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    pri_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rr_en       (rr_en),
        .release_i   (release_i),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may be changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_to);
        check({tag, "_grant"}, 32'(grant), 32'h00);
        check({tag, "_idx"},   32'(grant_idx), 32'd0);
        check({tag, "_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_to"},    32'(timeout), 32'(exp_to));
    endtask

    task automatic check_grant(input string tag, input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        check({tag, "_grant"}, 32'(grant), 32'(oh));
        check({tag, "_idx"},   32'(grant_idx), 32'(idx));
        check({tag, "_valid"}, 32'(grant_valid), 32'd1);
    endtask

    task automatic drain();
        req       = 8'h00;
        release_i = 1'b0;
        step();
        step();
        check_idle("drain", 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 8'h66; rr_en = 1'b0; release_i = 1'b0;

        // Reset holds everything low even with requests present.
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset", 1'b0);
        end
        rst = 1'b0; req = 8'h00;
        step();

        // Fixed priority, release in the second grant cycle, regrant to top.
        rr_en = 1'b0; req = 8'h43;
        step(); check_grant("fix_c1", 3'd6);
        step(); check_grant("fix_c2", 3'd6);
        release_i = 1'b1;
        step(); check_idle("fix_dead", 1'b0);
        release_i = 1'b0;
        step(); check_grant("fix_regrant", 3'd6);
        drain();

        // Round-robin from a cleared last: 7,6,...,0,7.
        rst = 1'b1; step(); rst = 1'b0;
        rr_en = 1'b1; req = 8'hFF; release_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] e;
            e = 3'(7 - i);
            step(); check_grant("rr", e);
            step(); check_idle("rr_dead", 1'b0);
        end
        drain();

        // Timeout after exactly 4 grant cycles, then regrant.
        rr_en = 1'b0; req = 8'h10;
        for (int c = 0; c < 4; c++) begin
            step(); check_grant("to_hold", 3'd4);
            check("to_no_pulse", 32'(timeout), 32'd0);
        end
        step(); check_idle("to_dead", 1'b1);
        step(); check_grant("to_regrant", 3'd4);
        check("to_regrant_pulse", 32'(timeout), 32'd0);
        // Release on the final hold cycle wins over the timeout.
        step(); step(); step();
        release_i = 1'b1;
        step(); check_idle("to_rel_prec", 1'b0);
        drain();

        // Request drop of the grantee ends the grant without a timeout.
        req = 8'h75;
        step(); check_grant("drop_c1", 3'd6);
        step(); check_grant("drop_c2", 3'd6);
        req = 8'h35;
        step(); check_idle("drop_dead", 1'b0);
        step(); check_grant("drop_next", 3'd5);
        drain();

        // Reset mid-grant clears outputs and the round-robin pointer.
        req = 8'h10;
        step(); check_grant("mid_pre", 3'd4);
        rst = 1'b1; rr_en = 1'b1; req = 8'hFF;
        step(); check_idle("mid_rst", 1'b0);
        rst = 1'b0;
        step(); check_grant("mid_post", 3'd7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
